// File: rtl/rope_speed_sched_if.sv
// Bus between the speed scheduler and the game logic: requests/controls in, speeds/directions out.
interface rope_speed_sched_if #(
    parameter int unsigned CHANNELS = 6,
    parameter int unsigned SPEED_W  = 7
);
    logic [CHANNELS-1:0]         req;
    logic                        freeze;
    logic [3:0]                  level;
    logic                        ready;
    logic [CHANNELS-1:0]         ack;
    logic [CHANNELS*SPEED_W-1:0] X_SPEED;
    logic [CHANNELS-1:0]         X_DIR;

    modport master (output req, freeze, level, input ready, ack, X_SPEED, X_DIR);
    modport slave  (input req, freeze, level, output ready, ack, X_SPEED, X_DIR);
endinterface

// File: rtl/rope_speed_sched.sv
// Per-channel random speed/direction generator: LFSR-driven initial fill, then
// round-robin refresh of requested channels with level bias and saturation.
module rope_speed_sched #(
    parameter int unsigned CHANNELS   = 6,
    parameter int unsigned SPEED_W    = 7,
    parameter int unsigned MIN_SPEED  = 2,
    parameter int unsigned MAX_SPEED  = 20,
    parameter int unsigned LEVEL_STEP = 2,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic               clk,
    input  logic               resetN,
    rope_speed_sched_if.slave  bus
);
    localparam int unsigned IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CW       = SPEED_W + 8;
    localparam int unsigned RANGE    = MAX_SPEED - MIN_SPEED + 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic [IDX_W:0]   CH_N     = (IDX_W+1)'(CHANNELS);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]                  state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [IDX_W-1:0]            rr_q, rr_d;
    logic [15:0]                 lfsr_q, lfsr_d;
    logic [CHANNELS-1:0]         pend_q, pend_d;
    logic [CHANNELS-1:0]         ack_q, ack_d;
    logic                        ready_q, ready_d;
    logic [CHANNELS*SPEED_W-1:0] speed_q, speed_d;
    logic [CHANNELS-1:0]         dir_q, dir_d;

    logic [CW-1:0]      prod, raw;
    logic [SPEED_W-1:0] cand_speed;
    logic               cand_dir;
    logic [IDX_W:0]     sum;
    logic [IDX_W-1:0]   gnt_idx, wr_idx;
    logic               found, wr_en;
    logic [CHANNELS-1:0] grant;

    // Candidate value from the current LFSR state
    always_comb begin
        prod       = CW'(lfsr_q[7:0]) * CW'(RANGE);
        raw        = CW'(MIN_SPEED) + (prod >> 8) + CW'(bus.level) * CW'(LEVEL_STEP);
        cand_speed = (raw > CW'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED) : raw[SPEED_W-1:0];
        cand_dir   = lfsr_q[15];
    end

    // First pending channel at or after rr, wrapping
    always_comb begin
        sum     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned off = 0; off < CHANNELS; off++) begin
            sum = {1'b0, rr_q} + (IDX_W+1)'(off);
            if (sum >= CH_N) sum = sum - CH_N;
            if (!found && pend_q[sum[IDX_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        ack_d   = '0;
        grant   = '0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        lfsr_d  = (lfsr_q == 16'h0000) ? 16'h0001
                                       : ((lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000));
        case (state_q)
            S_INIT: begin
                wr_en  = 1'b1;
                wr_idx = idx_q;
                if (idx_q == LAST_IDX) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_RUN: begin
                if (!bus.freeze && found) begin
                    grant[gnt_idx] = 1'b1;
                    ack_d          = grant;
                    wr_en          = 1'b1;
                    wr_idx         = gnt_idx;
                    rr_d           = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
                end
            end
            default: state_d = S_INIT;
        endcase
        if (wr_en) begin
            speed_d[wr_idx*SPEED_W +: SPEED_W] = cand_speed;
            dir_d[wr_idx]                      = cand_dir;
        end
        // A request on the channel granted this cycle re-arms it
        pend_d  = (pend_q & ~grant) | bus.req;
        ready_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_INIT;
            idx_q   <= '0;
            rr_q    <= '0;
            lfsr_q  <= SEED_EFF;
            pend_q  <= '0;
            ack_q   <= '0;
            ready_q <= 1'b0;
            speed_q <= '0;
            dir_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            lfsr_q  <= lfsr_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            ready_q <= ready_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.ack     = ack_q;
    assign bus.X_SPEED = speed_q;
    assign bus.X_DIR   = dir_q;
endmodule

// File: doc/rope_speed_sched.md
# rope_speed_sched

Parametrised per-channel random speed generator for the VGA game objects (ropes, enemies). Holds one speed value and one direction bit per channel. Fills every channel after reset, then refreshes individual channels on request through a round-robin arbiter. An internal 16-bit LFSR drives all values, and a level input biases speeds upward with saturation.

## Interface
- CHANNELS, 6: number of independent speed channels (1..16).
- SPEED_W, 7: width of each speed value.
- MIN_SPEED, 2: lowest generated speed before level bias.
- MAX_SPEED, 20: highest legal speed; also the saturation ceiling (MIN_SPEED <= MAX_SPEED < 2**SPEED_W).
- LEVEL_STEP, 2: speed added per level unit.
- SEED, 16'hACE1: LFSR reset value; 0 is illegal and is replaced by 16'h0001.

Ports:
- clk  in  1  system clock; one clock domain.
- resetN  in  1  asynchronous, active-low reset.
- req  in  CHANNELS  request a new speed for channel i; level-sampled every cycle.
- freeze  in  1  while high, no channel is updated; requests still accumulate.
- level  in  4  difficulty bias, unsigned.
- ready  out  1  high once the initial fill is complete.
- ack  out  CHANNELS  one-cycle pulse on the channel updated that cycle (one-hot or zero).
- X_SPEED  out  CHANNELS x SPEED_W  current speed per channel.
- X_DIR  out  CHANNELS  direction per channel (1 = right).

## Operation
- LFSR: 16-bit Galois, shifts right every cycle after reset, including during INIT and freeze. Next value = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0). If the value is ever 0, load 16'h0001.
- Candidate speed, computed from the current LFSR value:
  - RANGE = MAX_SPEED - MIN_SPEED + 1.
  - scaled = (lfsr[7:0] * RANGE) >> 8, range 0..RANGE-1.
  - raw = MIN_SPEED + scaled + level * LEVEL_STEP, using SPEED_W+8 bit intermediates.
  - speed = min(raw, MAX_SPEED).
  - dir = lfsr[15].
- FSM states: INIT, RUN.
- INIT: index counter runs 0..CHANNELS-1. Each cycle it writes speed/dir into channel[index]. No ack and no arbitration in INIT. After the write to channel CHANNELS-1, go to RUN and set ready = 1. freeze is ignored in INIT.
- Pending register, CHANNELS bits: pending_next = (pending & ~grant) | req. req is OR-ed in during INIT as well. A req on the channel being granted in that same cycle re-arms pending, so it produces a second grant later.
- RUN: when freeze = 0 and pending != 0, grant the first pending channel at or after pointer rr, wrapping modulo CHANNELS. The grant writes speed/dir, pulses ack for one cycle, and sets rr = granted + 1 (mod CHANNELS). At most one grant per cycle.
- Non-granted channels hold their values. X_SPEED/X_DIR change only on an INIT write or a grant.
- Reset, at any time including mid-INIT or mid-RUN:
  - X_SPEED = 0, X_DIR = 0, ack = 0, ready = 0.
  - pending = 0, rr = 0, index = 0, lfsr = SEED, state = INIT.

## Timing
- The first edge after resetN deasserts writes channel 0 using lfsr = SEED.
- INIT lasts CHANNELS cycles. ready is visible in the cycle after the last INIT write.
- Request latency: req high in cycle k is sampled into pending at the end of k. Uncontended, X_SPEED/X_DIR/ack update at the end of k+1. Worst case is k+CHANNELS with all channels pending.
- ack is registered and coincident with the new X_SPEED value. It never stays high for two consecutive cycles on the same channel unless pending re-armed.
- freeze affects grant decisions in the same cycle it is high. The grant sequence resumes from rr on the first cycle freeze is low.

## Test plan
- Reset/init (defaults):
  - Release reset → channel 0 = speed 18, dir 1. From SEED ACE1: 0xE1 → 225*19>>8 = 16, +2.
  - Channel 1 = speed 10, dir 1. From lfsr E270: 0x70 → 8, +2.
  - ready rises 6 cycles after the first write; ack stays 0 throughout INIT.
- Single request: req = 6'b000100 for one cycle in RUN → exactly one ack pulse on bit 2, two cycles later. Only channel 2 changes, and its value matches a reference LFSR model.
- Round-robin: req = 6'b111111 held for 1 cycle, rr = 0 → acks on channels 0,1,2,3,4,5 in consecutive cycles, then ack = 0.
- Freeze/saturation:
  - freeze = 1 while req pulses on channels 1 and 4 → no ack while frozen. Release → acks on 1, then 4.
  - level = 15 → every granted speed = 20, i.e. MAX.
- Re-arm: req[3] held high for 3 cycles → channel 3 is granted repeatedly, ack[3] pulses each cycle it is granted. After req drops, at most one more grant.
- Reset mid-run: assert resetN = 0 during a grant cycle → all outputs 0 immediately. After release, the INIT sequence exactly repeats the first scenario (18, 10, ...).
